// File: rtl/hc_sr04_echo_gen.sv
// HC-SR04 ultrasonic sensor emulator: watches the trigger pulse from the
// sensor controller and answers with an echo pulse whose width encodes a
// programmable distance. Small register file for distance, control, status
// and a completed-echo counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a synced trigger rising edge (enable must be 1)
// TRIG    | trigger high, measuring its width
// BURST   | emulated ultrasonic burst time before echo rises
// ECHO    | echo output high for the distance-derived width
// HOLDOFF | quiet time after echo falls; triggers ignored
module hc_sr04_echo_gen #(
   parameter int clk_freq   = 25000000,
   parameter int holdoff_us = 1000,
   parameter int burst_us   = 200
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        cs,
   input  logic [31:0] addr,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] d_in,
   output logic [31:0] d_out,
   input  logic        trigger,
   output logic        echo
);

   localparam int US = clk_freq / 1000000;
   // The rising-edge cycle is consumed in IDLE, so TRIG has counted one
   // fewer high cycle than the trigger actually spent high.
   localparam logic [23:0] TRIG_MIN  = 24'(10 * US - 1);
   localparam logic [23:0] BURST_LEN = 24'(burst_us * US);
   localparam logic [23:0] HOLD_LEN  = 24'(holdoff_us * US);
   localparam logic [23:0] NOOBJ_LEN = 24'(38000 * US);
   localparam logic [23:0] CM_LEN    = 24'(58 * US);
   localparam logic [8:0]  DIST_MIN  = 9'd2;
   localparam logic [8:0]  DIST_MAX  = 9'd400;
   localparam logic [8:0]  DIST_RST  = 9'd100;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_TRIG    = 3'd1,
      S_BURST   = 3'd2,
      S_ECHO    = 3'd3,
      S_HOLDOFF = 3'd4
   } state_t;

   state_t      state_q;
   logic [23:0] cnt_q;
   logic [8:0]  lat_dist_q;
   logic        lat_noobj_q;
   logic        echo_q;

   logic        trig_s1_q, trig_s2_q, trig_prev_q;

   logic [8:0]  dist_q, dist_d;
   logic        en_q, en_d;
   logic        noobj_q, noobj_d;
   logic        short_q, short_d;
   logic [15:0] count_q, count_d;

   logic        wr_dist, wr_ctrl, wr_count;
   logic        en_next;
   logic        trig_rise;
   logic        echo_done;
   logic        short_evt;
   logic        busy;
   logic [23:0] echo_len;
   logic        unused_bits;

   assign wr_dist  = cs & wr & (addr[3:2] == 2'd0);
   assign wr_ctrl  = cs & wr & (addr[3:2] == 2'd1);
   assign wr_count = cs & wr & (addr[3:2] == 2'd3);

   // A write clearing enable takes the FSM out on the same edge.
   assign en_next   = wr_ctrl ? d_in[0] : en_q;
   assign trig_rise = trig_s2_q & ~trig_prev_q;
   assign busy      = (state_q != S_IDLE);
   assign echo_len  = lat_noobj_q ? NOOBJ_LEN : 24'(lat_dist_q) * CM_LEN;

   assign echo_done = (state_q == S_ECHO) && (cnt_q == 24'd0) && en_next;
   assign short_evt = (state_q == S_TRIG) && !trig_s2_q && (cnt_q < TRIG_MIN) && en_next;

   assign echo = echo_q;

   assign unused_bits = ^{addr[31:4], addr[1:0], d_in[31:16]};

   // Two-flop synchronizer plus a delayed copy for edge detection.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         trig_s1_q   <= 1'b0;
         trig_s2_q   <= 1'b0;
         trig_prev_q <= 1'b0;
      end else begin
         trig_s1_q   <= trigger;
         trig_s2_q   <= trig_s1_q;
         trig_prev_q <= trig_s2_q;
      end
   end

   // Register file next-state: clamped distance, control, sticky flag, counter.
   always_comb begin
      dist_d  = dist_q;
      en_d    = en_next;
      noobj_d = wr_ctrl ? d_in[1] : noobj_q;
      short_d = short_q;
      count_d = count_q;
      if (wr_dist) begin
         if (d_in[15:0] < 16'(DIST_MIN))
            dist_d = DIST_MIN;
         else if (d_in[15:0] > 16'(DIST_MAX))
            dist_d = DIST_MAX;
         else
            dist_d = d_in[8:0];
      end
      if (echo_done)
         count_d = count_q + 16'd1;
      if (short_evt)
         short_d = 1'b1;
      // A COUNT write beats a coincident increment or short-trigger event.
      if (wr_count) begin
         count_d = 16'd0;
         short_d = 1'b0;
      end
   end

   // Register file state.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         dist_q  <= DIST_RST;
         en_q    <= 1'b0;
         noobj_q <= 1'b0;
         short_q <= 1'b0;
         count_q <= 16'd0;
      end else begin
         dist_q  <= dist_d;
         en_q    <= en_d;
         noobj_q <= noobj_d;
         short_q <= short_d;
         count_q <= count_d;
      end
   end

   // Measurement FSM with shared duration counter and registered echo.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         cnt_q       <= 24'd0;
         lat_dist_q  <= DIST_RST;
         lat_noobj_q <= 1'b0;
         echo_q      <= 1'b0;
      end else if (!en_next) begin
         state_q <= S_IDLE;
         cnt_q   <= 24'd0;
         echo_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               echo_q <= 1'b0;
               if (trig_rise) begin
                  state_q <= S_TRIG;
                  cnt_q   <= 24'd0;
               end
            end
            S_TRIG: begin
               if (trig_s2_q) begin
                  if (cnt_q != '1)
                     cnt_q <= cnt_q + 24'd1;
               end else if (cnt_q >= TRIG_MIN) begin
                  lat_dist_q  <= dist_q;
                  lat_noobj_q <= noobj_q;
                  cnt_q       <= BURST_LEN - 24'd1;
                  state_q     <= S_BURST;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_BURST: begin
               if (cnt_q == 24'd0) begin
                  state_q <= S_ECHO;
                  echo_q  <= 1'b1;
                  cnt_q   <= echo_len - 24'd1;
               end else begin
                  cnt_q <= cnt_q - 24'd1;
               end
            end
            S_ECHO: begin
               if (cnt_q == 24'd0) begin
                  state_q <= S_HOLDOFF;
                  echo_q  <= 1'b0;
                  cnt_q   <= HOLD_LEN - 24'd1;
               end else begin
                  cnt_q <= cnt_q - 24'd1;
               end
            end
            S_HOLDOFF: begin
               if (cnt_q == 24'd0)
                  state_q <= S_IDLE;
               else
                  cnt_q <= cnt_q - 24'd1;
            end
            default: begin
               state_q <= S_IDLE;
               echo_q  <= 1'b0;
            end
         endcase
      end
   end

   // Combinational read mux, zero when not selected.
   always_comb begin
      d_out = 32'h0;
      if (cs & rd) begin
         case (addr[3:2])
            2'd0: d_out = {23'd0, dist_q};
            2'd1: d_out = {30'd0, noobj_q, en_q};
            2'd2: d_out = {27'd0, state_q, short_q, busy};
            2'd3: d_out = {16'd0, count_q};
            default: d_out = 32'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_hc_sr04_echo_gen.sv
// Bench for hc_sr04_echo_gen, run at a 1 MHz clock (US = 1) so the full
// 400 cm and no-object widths fit in a short run.
module tb_hc_sr04_echo_gen;

   localparam int CLK_FREQ = 1000000;
   localparam int HOLD_US  = 30;
   localparam int BURST_US = 20;
   localparam int US       = CLK_FREQ / 1000000;
   localparam int B        = BURST_US * US;
   localparam int H        = HOLD_US * US;
   localparam int TMIN     = 10 * US;
   localparam int SYNC     = 2;

   localparam logic [31:0] A_DIST = 32'h0, A_CTRL = 32'h4, A_STAT = 32'h8, A_CNT = 32'hC;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
   logic [31:0] addr = 32'h0, d_in = 32'h0;
   logic [31:0] d_out;
   logic        trigger = 1'b0;
   logic        echo;

   hc_sr04_echo_gen #(
      .clk_freq  (CLK_FREQ),
      .holdoff_us(HOLD_US),
      .burst_us  (BURST_US)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .cs     (cs),
      .addr   (addr),
      .rd     (rd),
      .wr     (wr),
      .d_in   (d_in),
      .d_out  (d_out),
      .trigger(trigger),
      .echo   (echo)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Echo edge monitor, sampled just after each rising edge.
   logic echo_prev = 1'b0;
   int   rise_cnt = 0, fall_cnt = 0, rise_cyc = 0, fall_cyc = 0;
   always @(posedge clk) begin
      #1;
      if (echo && !echo_prev) begin rise_cnt++; rise_cyc = cyc; end
      if (!echo && echo_prev) begin fall_cnt++; fall_cyc = cyc; end
      echo_prev = echo;
   end

   int n_cmp = 0, n_err = 0;

   // Reference model state
   int m_dist = 100, m_count = 0;
   bit m_noobj = 0, m_short = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int clamp_cm(int raw);
      if (raw < 2) return 2;
      if (raw > 400) return 400;
      return raw;
   endfunction

   function automatic int echo_cycles(int cm, bit noobj);
      return noobj ? 38000 * US : cm * 58 * US;
   endfunction

   task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
      cs = 1'b1; rd = 1'b1; addr = a;
      #1 v = d_out;
      cs = 1'b0; rd = 1'b0;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
      @(negedge clk);
      cs = 1'b1; wr = 1'b1; addr = a; d_in = v;
      @(posedge clk);
      #1 cs = 1'b0; wr = 1'b0;
   endtask

   task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] v;
      bus_read(a, v);
      check_val(tag, v, exp);
   endtask

   function automatic logic [31:0] exp_status_idle();
      return {27'd0, 3'd0, m_short, 1'b0};
   endfunction

   // Trigger held high for n sampling edges; k = first edge sampling it low.
   task automatic pulse(input int n, output int k);
      @(negedge clk);
      trigger = 1'b1;
      repeat (n) @(negedge clk);
      trigger = 1'b0;
      k = cyc + 1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic wait_rise(input int r0, input int budget);
      int t = 0;
      while (rise_cnt == r0 && t < budget) begin @(negedge clk); t++; end
   endtask

   task automatic wait_fall(input int f0, input int budget);
      int t = 0;
      while (fall_cnt == f0 && t < budget) begin @(negedge clk); t++; end
   endtask

   // One measurement against the model; optionally rewrites DIST mid-burst.
   task automatic run_meas(input string tag, input int n, input bit chg, input int new_raw);
      int r0, f0, k, w;
      bit acc;
      logic [31:0] v;
      r0  = rise_cnt;
      f0  = fall_cnt;
      acc = (n >= TMIN);
      w   = echo_cycles(m_dist, m_noobj);
      pulse(n, k);
      if (acc) begin
         if (chg) begin
            repeat (4) @(negedge clk);
            bus_write(A_DIST, new_raw);
            m_dist = clamp_cm(new_raw);
         end
         wait_rise(r0, SYNC + B + 20);
         check_val({tag, "_rise"}, rise_cnt, r0 + 1);
         check_val({tag, "_delay"}, rise_cyc - k, SYNC + B);
         wait_fall(f0, w + 20);
         check_val({tag, "_width"}, fall_cyc - rise_cyc, w);
         m_count = (m_count + 1) & 16'hFFFF;
         wait_until(fall_cyc + H - 1);
         bus_read(A_STAT, v);
         check_val({tag, "_hold_busy"}, v[0], 1'b1);
         @(negedge clk);
         bus_read(A_STAT, v);
         check_val({tag, "_hold_done"}, v[0], 1'b0);
         read_chk({tag, "_count"}, A_CNT, m_count);
      end else begin
         repeat (SYNC + B + 10) @(negedge clk);
         check_val({tag, "_noecho"}, rise_cnt, r0);
         m_short = 1;
         read_chk({tag, "_status"}, A_STAT, exp_status_idle());
      end
   endtask

   initial begin
      #(98000 * 10);
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int k, r0, f0, w, raw, nr, n;
      logic [31:0] v;

      repeat (3) @(negedge clk);
      check_val("rst_echo", echo, 1'b0);
      read_chk("rst_dist", A_DIST, 100);
      read_chk("rst_ctrl", A_CTRL, 0);
      read_chk("rst_stat", A_STAT, 0);
      read_chk("rst_count", A_CNT, 0);
      resetn = 1'b1;

      // Disabled: trigger is ignored entirely.
      pulse(12, k);
      repeat (SYNC + B + 10) @(negedge clk);
      check_val("dis_noecho", rise_cnt, 0);
      read_chk("dis_stat", A_STAT, 0);

      bus_write(A_CTRL, 32'h1);
      read_chk("ctrl_en", A_CTRL, 1);
      bus_write(A_DIST, 10);
      m_dist = 10;
      read_chk("dist10", A_DIST, 10);

      // Minimum-width trigger accepted, one short of it rejected.
      run_meas("min_trig", TMIN, 0, 0);
      run_meas("short_trig", TMIN - 1, 0, 0);
      bus_write(A_CNT, 32'h0);
      m_count = 0; m_short = 0;
      read_chk("clr_stat", A_STAT, exp_status_idle());
      read_chk("clr_count", A_CNT, 0);

      // Clamp boundaries, then a full-range measurement.
      bus_write(A_DIST, 0);
      read_chk("clamp_lo", A_DIST, 2);
      bus_write(A_DIST, 1000);
      m_dist = 400;
      read_chk("clamp_hi", A_DIST, 400);
      run_meas("cm400", TMIN + 3, 0, 0);

      // No object, with triggers during ECHO and across the end of HOLDOFF.
      bus_write(A_CTRL, 32'h3);
      m_noobj = 1;
      read_chk("ctrl_noobj", A_CTRL, 3);
      r0 = rise_cnt; f0 = fall_cnt;
      pulse(TMIN, k);
      wait_rise(r0, SYNC + B + 20);
      check_val("noobj_delay", rise_cyc - k, SYNC + B);
      repeat (50) @(negedge clk);
      pulse(15, k);
      wait_fall(f0, echo_cycles(0, 1) + 20);
      check_val("noobj_width", fall_cyc - rise_cyc, echo_cycles(0, 1));
      m_count++;
      wait_until(fall_cyc + 5);
      trigger = 1'b1;
      repeat (H + 30) @(negedge clk);
      trigger = 1'b0;
      repeat (SYNC + B + 10) @(negedge clk);
      check_val("noobj_single", rise_cnt, r0 + 1);
      read_chk("noobj_count", A_CNT, m_count);
      read_chk("noobj_idle", A_STAT, exp_status_idle());
      bus_write(A_CTRL, 32'h1);
      m_noobj = 0;

      // Randomized measurements, some with a DIST rewrite during BURST.
      for (int i = 0; i < 8; i++) begin
         raw = $urandom_range(0, 16);
         nr  = $urandom_range(0, 16);
         n   = $urandom_range(TMIN - 3, TMIN + 4);
         bus_write(A_DIST, raw);
         m_dist = clamp_cm(raw);
         read_chk("rnd_dist", A_DIST, m_dist);
         run_meas("rnd", n, bit'($urandom_range(0, 1)), nr);
      end

      // COUNT clear coincident with echo completion: clear wins.
      bus_write(A_DIST, 2);
      m_dist = 2;
      w = echo_cycles(2, 0);
      r0 = rise_cnt; f0 = fall_cnt;
      pulse(TMIN, k);
      wait_rise(r0, SYNC + B + 20);
      wait_until(rise_cyc + w - 2);
      bus_write(A_CNT, 32'h0);
      m_count = 0; m_short = 0;
      wait_fall(f0, 20);
      check_val("coin_width", fall_cyc - rise_cyc, w);
      read_chk("coin_count", A_CNT, 0);
      repeat (H + 5) @(negedge clk);

      // Enable cleared mid-ECHO.
      bus_write(A_DIST, 20);
      m_dist = 20;
      r0 = rise_cnt;
      pulse(TMIN, k);
      wait_rise(r0, SYNC + B + 20);
      repeat (300) @(negedge clk);
      bus_write(A_CTRL, 32'h0);
      check_val("dis_echo0", echo, 1'b0);
      bus_read(A_STAT, v);
      check_val("dis_busy0", v[0], 1'b0);
      read_chk("dis_count", A_CNT, m_count);
      bus_write(A_CTRL, 32'h1);

      // Reset asserted mid-BURST, with non-default register contents.
      bus_write(A_DIST, 50);
      pulse(TMIN - 5, k);
      repeat (SYNC + B + 5) @(negedge clk);
      r0 = rise_cnt;
      pulse(TMIN, k);
      wait_until(k + SYNC + 5);
      bus_read(A_STAT, v);
      check_val("burst_busy", v[1:0], 2'b11);
      resetn = 1'b0;
      @(posedge clk);
      #1;
      check_val("mid_rst_echo", echo, 1'b0);
      read_chk("mid_rst_dist", A_DIST, 100);
      read_chk("mid_rst_ctrl", A_CTRL, 0);
      read_chk("mid_rst_stat", A_STAT, 0);
      read_chk("mid_rst_count", A_CNT, 0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (SYNC + B + 10) @(negedge clk);
      check_val("mid_rst_noecho", rise_cnt, r0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
